// File: rtl/bus_init_sequencer.sv
// Power-up/initialisation sequencer for the MOPSHUB bus array: powers, settles and trims each
// enabled bus in order, then signs on. Define MOPSHUB_INIT_RETRY_EN to retry a timed-out trim once.
module bus_init_sequencer #(
  parameter int unsigned N_BUS    = 32,
  parameter int unsigned BUS_W    = $clog2(N_BUS),
  parameter int unsigned SETTLE_W = 8,
  parameter int unsigned TMO_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_init,
  input  logic [BUS_W-1:0]    n_buses,
  input  logic [N_BUS-1:0]    bus_mask,
  input  logic                osc_auto_trim,
  input  logic [SETTLE_W-1:0] settle_cfg,
  input  logic [TMO_W-1:0]    tmo_cfg,
  input  logic                trim_done,
  input  logic                endwait_all,
  output logic                start_init_ack,
  output logic                power_bus_en,
  output logic [BUS_W-1:0]    power_bus_cnt,
  output logic                start_trim,
  output logic                end_trim_bus,
  output logic                end_power_init,
  output logic                sign_on_sig,
  output logic                end_init,
  output logic                busy,
  output logic [N_BUS-1:0]    bus_fail,
  output logic [BUS_W:0]      fail_cnt
);

  typedef enum logic [2:0] {
    StIdle, StPower, StSettle, StTrimReq, StTrimWait, StNext, StSignOn, StDone
  } state_e;

  state_e              state_q, state_d;
  logic [BUS_W-1:0]    idx_q, idx_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [N_BUS-1:0]    fail_q, fail_d;
  logic [BUS_W:0]      fail_cnt_q, fail_cnt_d;
  logic                ack_q, ack_d;
  logic                last_bus, mark_fail;
`ifdef MOPSHUB_INIT_RETRY_EN
  logic                retry_q, retry_d;
`endif

  // An out-of-range n_buses is clamped to the last physical bus.
  assign last_bus = (idx_q == n_buses) || (idx_q == BUS_W'(N_BUS - 1));

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    settle_d       = settle_q;
    tmo_d          = tmo_q;
    fail_d         = fail_q;
    fail_cnt_d     = fail_cnt_q;
    ack_d          = 1'b0;
    mark_fail      = 1'b0;
    power_bus_en   = 1'b0;
    start_trim     = 1'b0;
    end_trim_bus   = 1'b0;
    end_power_init = 1'b0;
    sign_on_sig    = 1'b0;
    end_init       = 1'b0;
`ifdef MOPSHUB_INIT_RETRY_EN
    retry_d        = retry_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start_init) begin
          idx_d      = '0;
          fail_d     = '0;
          fail_cnt_d = '0;
          ack_d      = 1'b1;
          state_d    = StPower;
        end
      end
      StPower: begin
`ifdef MOPSHUB_INIT_RETRY_EN
        retry_d = 1'b0;
`endif
        if (bus_mask[idx_q]) begin
          power_bus_en = 1'b1;
          settle_d     = settle_cfg;
          state_d      = StSettle;
        end else begin
          state_d = StNext;
        end
      end
      StSettle: begin
        power_bus_en = 1'b1;
        if (settle_q == '0) begin
          state_d = osc_auto_trim ? StTrimReq : StNext;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      StTrimReq: begin
        power_bus_en = 1'b1;
        start_trim   = 1'b1;
        tmo_d        = tmo_cfg;
        state_d      = StTrimWait;
      end
      StTrimWait: begin
        power_bus_en = 1'b1;
        if (tmo_q != '0) begin
          tmo_d = tmo_q - 1'b1;
        end
        // A zero load never reaches 1, so tmo_cfg = 0 waits forever; trim_done wins a tie.
        if (trim_done) begin
          end_trim_bus = 1'b1;
          state_d      = StNext;
        end else if (tmo_q == TMO_W'(1)) begin
`ifdef MOPSHUB_INIT_RETRY_EN
          if (!retry_q) begin
            retry_d = 1'b1;
            state_d = StTrimReq;
          end else begin
            mark_fail = 1'b1;
          end
`else
          mark_fail = 1'b1;
`endif
        end
        if (mark_fail) begin
          fail_d[idx_q] = 1'b1;
          fail_cnt_d    = fail_cnt_q + 1'b1;
          end_trim_bus  = 1'b1;
          state_d       = StNext;
        end
      end
      StNext: begin
        if (last_bus) begin
          end_power_init = 1'b1;
          state_d        = StSignOn;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = StPower;
        end
      end
      StSignOn: begin
        sign_on_sig = 1'b1;
        state_d     = StDone;
      end
      StDone: begin
        end_init = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Abort overrides everything: silent return to idle, failure record kept.
    if (endwait_all && (state_q != StIdle)) begin
      state_d        = StIdle;
      idx_d          = idx_q;
      fail_d         = fail_q;
      fail_cnt_d     = fail_cnt_q;
      power_bus_en   = 1'b0;
      start_trim     = 1'b0;
      end_trim_bus   = 1'b0;
      end_power_init = 1'b0;
      sign_on_sig    = 1'b0;
      end_init       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      settle_q   <= '0;
      tmo_q      <= '0;
      fail_q     <= '0;
      fail_cnt_q <= '0;
      ack_q      <= 1'b0;
`ifdef MOPSHUB_INIT_RETRY_EN
      retry_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      settle_q   <= settle_d;
      tmo_q      <= tmo_d;
      fail_q     <= fail_d;
      fail_cnt_q <= fail_cnt_d;
      ack_q      <= ack_d;
`ifdef MOPSHUB_INIT_RETRY_EN
      retry_q    <= retry_d;
`endif
    end
  end

  assign start_init_ack = ack_q;
  assign power_bus_cnt  = idx_q;
  assign busy           = (state_q != StIdle);
  assign bus_fail       = fail_q;
  assign fail_cnt       = fail_cnt_q;

endmodule

// File: tb/tb_bus_init_sequencer.sv
// Self-checking bench for bus_init_sequencer: per-cycle output timelines are compared against
// an event schedule computed from the sequencing rules; random configurations plus directed cases.
`timescale 1ns/1ps
module tb_bus_init_sequencer;
  localparam int unsigned N  = 32;
  localparam int unsigned BW = $clog2(N);
  localparam int MAXC = 1024;
`ifdef MOPSHUB_INIT_RETRY_EN
  localparam int ATTEMPTS = 2;
`else
  localparam int ATTEMPTS = 1;
`endif

  typedef struct packed {
    logic ack; logic pen; logic st; logic etr; logic epi; logic son; logic ein; logic busy;
    logic [BW-1:0] cnt;
  } snap_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_init, osc_auto_trim, trim_done, endwait_all;
  logic [BW-1:0] n_buses;
  logic [N-1:0]  bus_mask;
  logic [7:0]    settle_cfg;
  logic [15:0]   tmo_cfg;
  logic          start_init_ack, power_bus_en, start_trim, end_trim_bus;
  logic          end_power_init, sign_on_sig, end_init, busy;
  logic [BW-1:0] power_bus_cnt;
  logic [N-1:0]  bus_fail;
  logic [BW:0]   fail_cnt;

  always #5 clk = ~clk;

  bus_init_sequencer #(.N_BUS(N)) dut (
    .clk            (clk),
    .rst            (rst),
    .start_init     (start_init),
    .n_buses        (n_buses),
    .bus_mask       (bus_mask),
    .osc_auto_trim  (osc_auto_trim),
    .settle_cfg     (settle_cfg),
    .tmo_cfg        (tmo_cfg),
    .trim_done      (trim_done),
    .endwait_all    (endwait_all),
    .start_init_ack (start_init_ack),
    .power_bus_en   (power_bus_en),
    .power_bus_cnt  (power_bus_cnt),
    .start_trim     (start_trim),
    .end_trim_bus   (end_trim_bus),
    .end_power_init (end_power_init),
    .sign_on_sig    (sign_on_sig),
    .end_init       (end_init),
    .busy           (busy),
    .bus_fail       (bus_fail),
    .fail_cnt       (fail_cnt)
  );

  int            errors = 0;
  int            checks = 0;
  snap_t         exp_s[MAXC];
  snap_t         obs_s[MAXC];
  logic [N-1:0]  exp_fail;
  int            exp_fcnt;
  int            exp_len;
  logic [BW-1:0] prev_cnt;
  int            tdly[N];

  // Event schedule from the rules: bus b starts at cycle t; POWER, settle+1 SETTLE cycles,
  // optional trim attempts, then NEXT. Cycle 0 is the start_init cycle.
  task automatic build_model(input int abort_at);
    int t, s, e, last, st_c, d, att;
    bit done;
    for (int k = 0; k < MAXC; k++) exp_s[k] = '0;
    exp_fail = '0;
    exp_fcnt = 0;
    exp_s[0].cnt = prev_cnt;
    exp_s[1].ack = 1'b1;
    last = (int'(n_buses) > int'(N) - 1) ? int'(N) - 1 : int'(n_buses);
    t = 1;
    for (int b = 0; b <= last; b++) begin
      s = t;
      if (bus_mask[b]) begin
        e = t + int'(settle_cfg) + 1;
        if (osc_auto_trim) begin
          att = 0;
          done = 1'b0;
          while (!done) begin
            st_c = e + 1;
            exp_s[st_c].st = 1'b1;
            d = tdly[b];
            if (d > 0 && (tmo_cfg == 16'd0 || d <= int'(tmo_cfg))) begin
              e = st_c + d;
              done = 1'b1;
            end else begin
              e = st_c + int'(tmo_cfg);
              att++;
              if (att >= ATTEMPTS) begin
                done = 1'b1;
                if (abort_at < 0 || e < abort_at) begin
                  exp_fail[b] = 1'b1;
                  exp_fcnt++;
                end
              end
            end
          end
          exp_s[e].etr = 1'b1;
        end
        for (int k = s; k <= e; k++) exp_s[k].pen = 1'b1;
        t = e + 1;
      end else begin
        t = t + 1;
      end
      for (int k = s; k <= t; k++) begin
        exp_s[k].busy = 1'b1;
        exp_s[k].cnt  = BW'(b);
      end
      if (b == last) exp_s[t].epi = 1'b1;
      t++;
    end
    exp_s[t].son = 1'b1;
    exp_s[t + 1].ein = 1'b1;
    for (int k = t; k <= t + 1; k++) begin
      exp_s[k].busy = 1'b1;
      exp_s[k].cnt  = BW'(last);
    end
    exp_len = t + 2;
    for (int k = exp_len; k < MAXC; k++) exp_s[k].cnt = BW'(last);
    if (abort_at > 0 && abort_at < exp_len) begin
      exp_s[abort_at].pen = 1'b0;
      exp_s[abort_at].st  = 1'b0;
      exp_s[abort_at].etr = 1'b0;
      exp_s[abort_at].epi = 1'b0;
      exp_s[abort_at].son = 1'b0;
      exp_s[abort_at].ein = 1'b0;
      for (int k = abort_at + 1; k < MAXC; k++) begin
        exp_s[k] = '0;
        exp_s[k].cnt = exp_s[abort_at].cnt;
      end
      exp_len = abort_at + 1;
    end
    prev_cnt = exp_s[exp_len].cnt;
  endtask

  // Drives one sequence and records every cycle; acts as a trim engine answering tdly[bus]
  // cycles after each start_trim (never if tdly <= 0).
  task automatic run_capture(input int ncyc, input int abort_at, input int dup_at);
    int pend;
    pend = -1;
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk); #1;
      start_init  = (k == 0) || (k == dup_at);
      endwait_all = (k == abort_at);
      trim_done   = (k == pend);
      @(negedge clk);
      obs_s[k] = {start_init_ack, power_bus_en, start_trim, end_trim_bus, end_power_init,
                  sign_on_sig, end_init, busy, power_bus_cnt};
      if (start_trim) pend = (tdly[power_bus_cnt] > 0) ? k + tdly[power_bus_cnt] : -1;
    end
    start_init  = 1'b0;
    endwait_all = 1'b0;
    trim_done   = 1'b0;
  endtask

  task automatic set_all_tdly(input int d);
    for (int b = 0; b < int'(N); b++) tdly[b] = d;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({start_init_ack, power_bus_en, start_trim, end_trim_bus, end_power_init, sign_on_sig,
         end_init, busy} !== 8'h00) begin
      errors++;
      $display("FAIL reset_pulses: got %b required 00000000", {start_init_ack, power_bus_en,
               start_trim, end_trim_bus, end_power_init, sign_on_sig, end_init, busy});
    end
    checks++;
    if (power_bus_cnt !== '0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d required 0", power_bus_cnt);
    end
    checks++;
    if ({bus_fail, fail_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_fail: got %h/%0d required 0/0", bus_fail, fail_cnt);
    end
    rst = 1'b1;
    prev_cnt = '0;
  endtask

  task automatic test_basic_walk;
    int npen, c;
    n_buses = BW'(3); bus_mask = '1; osc_auto_trim = 1'b0; settle_cfg = 8'd4; tmo_cfg = 16'd0;
    set_all_tdly(0);
    build_model(-1);
    run_capture(exp_len + 3, -1, -1);
    npen = 0;
    c = -1;
    for (int k = 0; k < exp_len + 3; k++) begin
      checks++;
      if (obs_s[k] !== exp_s[k]) begin
        errors++;
        $display("FAIL basic_walk cycle %0d: got %h required %h", k, obs_s[k], exp_s[k]);
      end
      npen += int'(obs_s[k].pen);
      if (obs_s[k].epi) c = k;
    end
    checks++;
    if (npen !== 24) begin
      errors++;
      $display("FAIL basic_pen_cycles: got %0d required 24", npen);
    end
    checks++;
    if (c < 0 || {obs_s[c + 1].son, obs_s[c + 2].ein} !== 2'b11) begin
      errors++;
      $display("FAIL basic_end_chain: end_power_init at %0d, followers not consecutive", c);
    end
    checks++;
    if (fail_cnt !== '0) begin
      errors++;
      $display("FAIL basic_fail_cnt: got %0d required 0", fail_cnt);
    end
  endtask

  task automatic test_masked_trim;
    int nst, netr, stray;
    n_buses = BW'(31); bus_mask = 32'h0000_00F0; osc_auto_trim = 1'b1;
    settle_cfg = 8'd0; tmo_cfg = 16'd0;
    set_all_tdly(3);
    build_model(-1);
    run_capture(exp_len + 3, -1, -1);
    nst = 0; netr = 0; stray = 0;
    for (int k = 0; k < exp_len + 3; k++) begin
      checks++;
      if (obs_s[k] !== exp_s[k]) begin
        errors++;
        $display("FAIL masked_trim cycle %0d: got %h required %h", k, obs_s[k], exp_s[k]);
      end
      nst  += int'(obs_s[k].st);
      netr += int'(obs_s[k].etr);
      if (obs_s[k].pen && (obs_s[k].cnt < 4 || obs_s[k].cnt > 7)) stray++;
    end
    checks++;
    if (nst !== 4 || netr !== 4) begin
      errors++;
      $display("FAIL masked_trim_counts: got start_trim=%0d end_trim=%0d required 4/4", nst, netr);
    end
    checks++;
    if (stray !== 0) begin
      errors++;
      $display("FAIL masked_stray_power: got %0d cycles required 0", stray);
    end
  endtask

  task automatic test_timeout;
    int st2, etr2, nst2;
    n_buses = BW'(3); bus_mask = '1; osc_auto_trim = 1'b1; settle_cfg = 8'd2; tmo_cfg = 16'd10;
    set_all_tdly(3);
    tdly[2] = -1;
    build_model(-1);
    run_capture(exp_len + 3, -1, -1);
    st2 = -1; etr2 = -1; nst2 = 0;
    for (int k = 0; k < exp_len + 3; k++) begin
      checks++;
      if (obs_s[k] !== exp_s[k]) begin
        errors++;
        $display("FAIL timeout cycle %0d: got %h required %h", k, obs_s[k], exp_s[k]);
      end
      if (obs_s[k].st && obs_s[k].cnt == 2) begin st2 = k; nst2++; end
      if (obs_s[k].etr && obs_s[k].cnt == 2) etr2 = k;
    end
    checks++;
    if (bus_fail !== 32'h0000_0004 || fail_cnt !== 6'd1) begin
      errors++;
      $display("FAIL timeout_flags: got %h/%0d required 00000004/1", bus_fail, fail_cnt);
    end
    checks++;
    if (etr2 - st2 !== 10 || nst2 !== ATTEMPTS) begin
      errors++;
      $display("FAIL timeout_gap: got gap %0d tries %0d required 10/%0d", etr2 - st2, nst2,
               ATTEMPTS);
    end
  endtask

  task automatic test_trim_race;
    n_buses = BW'(2); bus_mask = '1; osc_auto_trim = 1'b1; settle_cfg = 8'd1; tmo_cfg = 16'd6;
    set_all_tdly(6);
    build_model(-1);
    run_capture(exp_len + 3, -1, -1);
    for (int k = 0; k < exp_len + 3; k++) begin
      checks++;
      if (obs_s[k] !== exp_s[k]) begin
        errors++;
        $display("FAIL trim_race cycle %0d: got %h required %h", k, obs_s[k], exp_s[k]);
      end
    end
    checks++;
    if (bus_fail !== '0 || fail_cnt !== '0) begin
      errors++;
      $display("FAIL trim_race_flags: got %h/%0d required 0/0", bus_fail, fail_cnt);
    end
  endtask

  task automatic test_abort;
    int nson;
    n_buses = BW'(31); bus_mask = '1; osc_auto_trim = 1'b0; settle_cfg = 8'd4; tmo_cfg = 16'd0;
    set_all_tdly(0);
    build_model(39);
    run_capture(exp_len + 5, 39, -1);
    nson = 0;
    for (int k = 0; k < exp_len + 5; k++) begin
      checks++;
      if (obs_s[k] !== exp_s[k]) begin
        errors++;
        $display("FAIL abort cycle %0d: got %h required %h", k, obs_s[k], exp_s[k]);
      end
      nson += int'(obs_s[k].son);
    end
    checks++;
    if (obs_s[39].cnt !== BW'(5) || obs_s[40].busy !== 1'b0 || obs_s[40].pen !== 1'b0 || nson != 0)
    begin
      errors++;
      $display("FAIL abort_state: got cnt=%0d busy=%b pen=%b son=%0d required 5/0/0/0",
               obs_s[39].cnt, obs_s[40].busy, obs_s[40].pen, nson);
    end
    n_buses = BW'(1);
    build_model(-1);
    run_capture(exp_len + 3, -1, -1);
    for (int k = 0; k < exp_len + 3; k++) begin
      checks++;
      if (obs_s[k] !== exp_s[k]) begin
        errors++;
        $display("FAIL abort_restart cycle %0d: got %h required %h", k, obs_s[k], exp_s[k]);
      end
    end
  endtask

  task automatic test_reset_mid;
    n_buses = BW'(3); bus_mask = '1; osc_auto_trim = 1'b1; settle_cfg = 8'd2; tmo_cfg = 16'd0;
    @(posedge clk); #1 start_init = 1'b1;
    @(posedge clk); #1 start_init = 1'b0;
    repeat (8) @(posedge clk);
    #1 start_init = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, power_bus_en, start_trim} !== 3'b110) begin
      errors++;
      $display("FAIL mid_trim_wait: got busy/pen/st=%b required 110",
               {busy, power_bus_en, start_trim});
    end
    @(posedge clk); #1 start_init = 1'b0;
    @(negedge clk);
    checks++;
    if (start_init_ack !== 1'b0 || power_bus_cnt !== '0) begin
      errors++;
      $display("FAIL busy_start_ignored: got ack=%b cnt=%0d required 0/0", start_init_ack,
               power_bus_cnt);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({start_init_ack, power_bus_en, start_trim, end_trim_bus, end_power_init, sign_on_sig,
         end_init, busy, power_bus_cnt, bus_fail, fail_cnt} !== '0) begin
      errors++;
      $display("FAIL async_reset: got busy=%b pen=%b cnt=%0d required all 0", busy, power_bus_en,
               power_bus_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    prev_cnt = '0;
  endtask

  task automatic test_random;
    logic [BW-1:0] saved;
    int abort_at, dup_at;
    for (int it = 0; it < 6; it++) begin
      n_buses       = BW'($urandom_range(1, 6));
      bus_mask      = N'($urandom);
      osc_auto_trim = 1'($urandom_range(0, 1));
      settle_cfg    = 8'($urandom_range(0, 5));
      tmo_cfg       = 16'($urandom_range(1, 12));
      for (int b = 0; b < int'(N); b++)
        tdly[b] = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(1, 15));
      saved = prev_cnt;
      build_model(-1);
      abort_at = -1;
      dup_at = (it % 2 == 1) ? 3 : -1;
      if (it == 4) begin
        abort_at = int'($urandom_range(2, exp_len - 1));
        dup_at = -1;
        prev_cnt = saved;
        build_model(abort_at);
      end
      run_capture(exp_len + 3, abort_at, dup_at);
      for (int k = 0; k < exp_len + 3; k++) begin
        checks++;
        if (obs_s[k] !== exp_s[k]) begin
          errors++;
          $display("FAIL random%0d cycle %0d: got %h required %h", it, k, obs_s[k], exp_s[k]);
        end
      end
      checks++;
      if (bus_fail !== exp_fail || fail_cnt !== (BW + 1)'(exp_fcnt)) begin
        errors++;
        $display("FAIL random%0d_flags: got %h/%0d required %h/%0d", it, bus_fail, fail_cnt,
                 exp_fail, exp_fcnt);
      end
    end
  endtask

  initial begin
    rst = 1'b0; start_init = 1'b0; endwait_all = 1'b0; trim_done = 1'b0;
    n_buses = '0; bus_mask = '0; osc_auto_trim = 1'b0; settle_cfg = '0; tmo_cfg = '0;
    set_all_tdly(0);
    test_reset;
    test_basic_walk;
    test_masked_trim;
    test_timeout;
    test_trim_race;
    test_abort;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_init_sequencer.md
Name: bus_init_sequencer

Overview:
Parametrised power-up/initialisation sequencer for the MOPSHUB bus array; successor to the fixed 32-bus init flow. Walks buses 0..n_buses in order: powers each enabled bus, waits a settle time, optionally runs oscillator trim with timeout, then issues a single sign-on once all buses are done. Sits between the hub core and the per-bus power/trim logic. Adds a runtime bus-enable mask, a trim timeout and per-bus failure flags.

Parameters:
N_BUS, 32, number of physical buses (2..64)
BUS_W, $clog2(N_BUS), width of bus index
SETTLE_W, 8, width of settle counter
TMO_W, 16, width of trim-timeout counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active low
start_init  in  1  one-cycle pulse; starts a sequence from IDLE
n_buses  in  BUS_W  index of last bus to process (N_BUS-1 = all)
bus_mask  in  N_BUS  1 = bus enabled; disabled buses are skipped
osc_auto_trim  in  1  1 = run trim phase per bus
settle_cfg  in  SETTLE_W  settle cycles after power enable
tmo_cfg  in  TMO_W  trim timeout in cycles (0 = no timeout)
trim_done  in  1  trim engine acknowledge, level or pulse
endwait_all  in  1  abort; return to IDLE at next edge
start_init_ack  out  1  one-cycle pulse when sequence accepted
power_bus_en  out  1  high while current bus is powered in POWER/SETTLE/TRIM
power_bus_cnt  out  BUS_W  index of current bus
start_trim  out  1  one-cycle trim request
end_trim_bus  out  1  one-cycle pulse when trim of a bus finishes (ok or fail)
end_power_init  out  1  one-cycle pulse after last bus processed
sign_on_sig  out  1  one-cycle pulse, one cycle after end_power_init
end_init  out  1  one-cycle pulse, one cycle after sign_on_sig
busy  out  1  high in every state except IDLE
bus_fail  out  N_BUS  sticky per-bus trim-timeout flags
fail_cnt  out  BUS_W+1  count of failed buses this sequence

Behaviour:
- Reset (rst=0): state IDLE; all outputs 0; counters 0.
- States: IDLE, POWER, SETTLE, TRIM_REQ, TRIM_WAIT, NEXT, SIGN_ON, DONE.
- IDLE: on start_init -> clear bus_fail, fail_cnt, power_bus_cnt=0; pulse start_init_ack; -> POWER. start_init ignored outside IDLE.
- POWER: if bus_mask[power_bus_cnt]=0 -> NEXT (power_bus_en stays 0). Else power_bus_en=1, load settle counter with settle_cfg -> SETTLE.
- SETTLE: decrement each cycle; at 0 -> TRIM_REQ if osc_auto_trim else NEXT. settle_cfg=0 leaves after exactly 1 cycle.
- TRIM_REQ: start_trim=1 for one cycle, load timeout counter -> TRIM_WAIT.
- TRIM_WAIT: trim_done=1 -> pulse end_trim_bus, -> NEXT. Timeout reaches 0 (tmo_cfg≠0) -> set bus_fail[idx], fail_cnt+1, pulse end_trim_bus, -> NEXT. trim_done and expiry in same cycle: success wins.
- NEXT: power_bus_en=0; if power_bus_cnt==n_buses or ==N_BUS-1 -> SIGN_ON with end_power_init pulse; else power_bus_cnt+1 -> POWER. n_buses>N_BUS-1 is clamped to N_BUS-1.
- SIGN_ON: sign_on_sig pulse -> DONE. DONE: end_init pulse -> IDLE. power_bus_cnt holds last value in IDLE.
- endwait_all high in any non-IDLE state: power_bus_en=0, no end/sign-on pulses, -> IDLE next edge; bus_fail/fail_cnt retained.
- Async reset mid-sequence: immediate return to reset values.
- All-buses-masked: each bus spends POWER+NEXT (2 cycles), then normal SIGN_ON/DONE.
- Latency per enabled bus, no trim: 1 (POWER) + settle_cfg+1 + 1 (NEXT) cycles.

Optional Feature:
MOPSHUB_INIT_RETRY_EN: when defined, a trim timeout triggers one retry (back to TRIM_REQ, new start_trim pulse, reloaded timeout); bus_fail/fail_cnt updated only if the retry also times out; end_trim_bus pulses once per bus. Without it, the first timeout marks failure immediately.

Test Plan:
- n_buses=3, mask=all 1, osc_auto_trim=0, settle_cfg=4 -> power_bus_cnt 0,1,2,3, each power_bus_en high 6 cycles; end_power_init, sign_on_sig, end_init on consecutive cycles; fail_cnt=0.
- n_buses=31, mask=0x0000_00F0, trim_done returns 3 cycles after start_trim -> exactly 4 start_trim and 4 end_trim_bus pulses at buses 4..7; others never assert power_bus_en.
- tmo_cfg=10, trim_done never asserted on bus 2, n_buses=3 -> bus_fail=0x4, fail_cnt=1, start_trim on bus 2 asserted 10 cycles before end_trim_bus (twice with MOPSHUB_INIT_RETRY_EN, fail after 2nd).
- trim_done asserted in the exact cycle timeout expires -> no bus_fail bit set.
- endwait_all pulse during SETTLE of bus 5 -> IDLE next cycle, power_bus_en=0, busy=0, no sign_on_sig; new start_init restarts at bus 0.
- rst low during TRIM_WAIT -> all outputs 0 immediately; start_init ignored while busy=1.
